// File: rtl/gf_pkg.sv
// gf_pkg: shared definitions for the bit-serial GF(2^m) ALU.
//   - gf_mode_e  : operation select encodings
//   - gf_state_e : top-level FSM states
//   - GF_DEFAULT_POLY : default low terms of the reduction polynomial (x^32 implicit)
//   - gf_xtime   : multiply-by-x with reduction, width and polynomial as arguments
package gf_pkg;

   typedef enum logic [1:0] {
      GF_ADD  = 2'b00,
      GF_MUL  = 2'b01,
      GF_SQR  = 2'b10,
      INT_ADD = 2'b11
   } gf_mode_e;

   typedef enum logic [1:0] {
      StLoad,
      StCompute,
      StOut
   } gf_state_e;

   localparam logic [31:0]  GF_DEFAULT_POLY = 32'h0000_008D;
   localparam int unsigned  GF_MAX_WIDTH    = 64;

   // Field elements are carried in a 64-bit container; bits at and above
   // 'width' are ignored on input and zero on output.
   function automatic logic [GF_MAX_WIDTH-1:0] gf_xtime(
      input logic [GF_MAX_WIDTH-1:0] x,
      input int unsigned             width,
      input logic [GF_MAX_WIDTH-1:0] poly
   );
      logic [GF_MAX_WIDTH-1:0] w_mask;
      logic [GF_MAX_WIDTH-1:0] w_res;
      logic                    w_msb;
      w_mask = (width >= GF_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
      w_msb  = ((x >> (width - 1)) & 64'd1) != 64'd0;
      w_res  = (x << 1) & w_mask;
      if (w_msb) begin
         w_res = w_res ^ (poly & w_mask);
      end
      return w_res;
   endfunction

endpackage

// File: rtl/gf_serial_mul.sv
// gf_serial_mul: iterative Horner multiplier over GF(2^m), one step per cycle,
// multiplier consumed MSB first. i_start performs the first step (accumulator
// treated as zero) and latches the multiplier; o_done is high in the cycle whose
// clock edge performs the m-th step, with o_product already showing that result.
// Ports:
//   clk, resetn   clock, async active-low reset
//   i_start       begin a new product (one-cycle pulse)
//   i_op_a        multiplicand, held stable by the caller for the whole product
//   i_mplier      multiplier, sampled with i_start
//   o_done        final step happens at the coming edge
//   o_product     accumulator value after the current step
module gf_serial_mul
   import gf_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  POLY       = DATA_WIDTH'(GF_DEFAULT_POLY)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_op_a,
   input  logic [DATA_WIDTH-1:0] i_mplier,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_product
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);

   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [CntW-1:0]       r_cnt;

   logic                  w_active;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_acc_cur;
   logic [DATA_WIDTH-1:0] w_mpl_cur;
   logic [CntW-1:0]       w_cnt_cur;
   logic [DATA_WIDTH-1:0] w_xt;
   logic [DATA_WIDTH-1:0] w_step;

   always_comb begin
      w_active  = i_start | r_busy;
      // On start the step works on a cleared accumulator and the fresh multiplier.
      w_acc_cur = i_start ? '0 : r_acc;
      w_mpl_cur = i_start ? i_mplier : r_mplier;
      w_cnt_cur = i_start ? '0 : r_cnt;
      w_xt      = DATA_WIDTH'(gf_xtime(64'(w_acc_cur), DATA_WIDTH, 64'(POLY)));
      w_step    = w_xt ^ (w_mpl_cur[DATA_WIDTH-1] ? i_op_a : '0);
      w_last    = (w_cnt_cur == CntW'(DATA_WIDTH - 1));
      o_done    = w_active & w_last;
      o_product = w_step;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_busy   <= 1'b0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_active) begin
         r_acc    <= w_step;
         r_mplier <= w_mpl_cur << 1;
         r_cnt    <= w_last ? '0 : (w_cnt_cur + CntW'(1));
         r_busy   <= ~w_last;
      end
   end

endmodule

// File: rtl/gf_serial_alu.sv
// gf_serial_alu: bit-serial GF(2^m) ALU. Two operands are deserialised LSB
// first, one of GF add / GF mul / GF square / integer add is applied, and the
// result is serialised LSB first. One frame in flight at a time.
// Ports:
//   clk, resetn          clock, async active-low reset
//   in_valid / in_ready  input bit handshake (ready only while loading)
//   a, b                 operand serial bits, LSB first
//   mode                 operation, sampled with the last input bit
//   out_valid/out_ready  output bit handshake
//   sum                  result serial bit, LSB first
//   out_last             marks result bit m-1
// All outputs decode registered state only.
module gf_serial_alu
   import gf_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  POLY       = DATA_WIDTH'(GF_DEFAULT_POLY)
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       a,
   input  logic       b,
   input  logic [1:0] mode,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       sum,
   output logic       out_last
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);

   gf_state_e             r_state,     w_state_nxt;
   gf_mode_e              r_mode,      w_mode_nxt;
   logic [DATA_WIDTH-1:0] r_op_a,      w_op_a_nxt;
   logic [DATA_WIDTH-1:0] r_op_b,      w_op_b_nxt;
   logic [DATA_WIDTH-1:0] r_res,       w_res_nxt;
   logic [CntW-1:0]       r_bit_cnt,   w_bit_cnt_nxt;
   logic                  r_mul_start, w_mul_start_nxt;

   logic                  w_cnt_last;
   logic                  w_mul_done;
   logic [DATA_WIDTH-1:0] w_mul_product;
   logic [DATA_WIDTH-1:0] w_mplier;
   logic [DATA_WIDTH-1:0] w_int_sum;

   // Squaring is a multiply with op_a as its own multiplier.
   assign w_mplier  = (r_mode == GF_SQR) ? r_op_a : r_op_b;
   assign w_int_sum = r_op_a + r_op_b;  // carry-out dropped by width
   assign w_cnt_last = (r_bit_cnt == CntW'(DATA_WIDTH - 1));

   gf_serial_mul #(
      .DATA_WIDTH (DATA_WIDTH),
      .POLY       (POLY)
   ) u_mul (
      .clk       (clk),
      .resetn    (resetn),
      .i_start   (r_mul_start),
      .i_op_a    (r_op_a),
      .i_mplier  (w_mplier),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_mode_nxt      = r_mode;
      w_op_a_nxt      = r_op_a;
      w_op_b_nxt      = r_op_b;
      w_res_nxt       = r_res;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_mul_start_nxt = 1'b0;

      unique case (r_state)
         StLoad: begin
            if (in_valid) begin
               w_op_a_nxt = {a, r_op_a[DATA_WIDTH-1:1]};
               w_op_b_nxt = {b, r_op_b[DATA_WIDTH-1:1]};
               if (w_cnt_last) begin
                  w_mode_nxt      = gf_mode_e'(mode);
                  w_bit_cnt_nxt   = '0;
                  w_state_nxt     = StCompute;
                  w_mul_start_nxt = (mode == GF_MUL) || (mode == GF_SQR);
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
               end
            end
         end

         StCompute: begin
            unique case (r_mode)
               GF_ADD: begin
                  w_res_nxt   = r_op_a ^ r_op_b;
                  w_state_nxt = StOut;
               end
               INT_ADD: begin
                  w_res_nxt   = w_int_sum;
                  w_state_nxt = StOut;
               end
               GF_MUL, GF_SQR: begin
                  if (w_mul_done) begin
                     w_res_nxt   = w_mul_product;
                     w_state_nxt = StOut;
                  end
               end
               default: w_state_nxt = StOut;
            endcase
            w_bit_cnt_nxt = '0;
         end

         StOut: begin
            if (out_ready) begin
               w_res_nxt = r_res >> 1;
               if (w_cnt_last) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = StLoad;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
               end
            end
         end

         default: begin
            w_state_nxt   = StLoad;
            w_bit_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StLoad;
         r_mode      <= GF_ADD;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_res       <= '0;
         r_bit_cnt   <= '0;
         r_mul_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode      <= w_mode_nxt;
         r_op_a      <= w_op_a_nxt;
         r_op_b      <= w_op_b_nxt;
         r_res       <= w_res_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_mul_start <= w_mul_start_nxt;
      end
   end

   assign in_ready  = (r_state == StLoad);
   assign out_valid = (r_state == StOut);
   assign sum       = (r_state == StOut) & r_res[0];
   assign out_last  = (r_state == StOut) & w_cnt_last;

endmodule

// File: tb/tb_gf_serial_alu.sv
// Bench for gf_serial_alu: an 8-bit AES-field instance and a default 32-bit
// instance share one stimulus driver selected by 'sel'. Results are compared
// with a shift-and-add GF reference model and directed known answers.
module tb_gf_serial_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       sel;
   logic       t_in_valid, t_a, t_b, t_out_ready;
   logic [1:0] t_mode;

   logic       in_valid8, in_ready8, a8, b8, out_valid8, out_ready8, sum8, out_last8;
   logic [1:0] mode8;
   logic       in_valid32, in_ready32, a32, b32, out_valid32, out_ready32, sum32, out_last32;
   logic [1:0] mode32;

   assign in_valid8   = ~sel & t_in_valid;
   assign a8          = ~sel & t_a;
   assign b8          = ~sel & t_b;
   assign mode8       = sel ? 2'b00 : t_mode;
   assign out_ready8  = ~sel & t_out_ready;
   assign in_valid32  = sel & t_in_valid;
   assign a32         = sel & t_a;
   assign b32         = sel & t_b;
   assign mode32      = sel ? t_mode : 2'b00;
   assign out_ready32 = sel & t_out_ready;

   logic o_in_ready, o_out_valid, o_sum, o_out_last;
   assign o_in_ready  = sel ? in_ready32  : in_ready8;
   assign o_out_valid = sel ? out_valid32 : out_valid8;
   assign o_sum       = sel ? sum32       : sum8;
   assign o_out_last  = sel ? out_last32  : out_last8;

   gf_serial_alu #(
      .DATA_WIDTH (8),
      .POLY       (8'h1B)
   ) u_dut8 (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .mode      (mode8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .out_last  (out_last8)
   );

   gf_serial_alu u_dut32 (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .a         (a32),
      .b         (b32),
      .mode      (mode32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .sum       (sum32),
      .out_last  (out_last32)
   );

   int          n_total;
   int          n_bad;
   int          cur_m;
   logic [63:0] cur_poly;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Reference: add/xor directly, multiply by LSB-first shift-and-add with reduction.
   function automatic logic [63:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] md, input int m,
                                          input logic [63:0] poly);
      logic [63:0] mask, p, aa, bb;
      mask = (m >= 64) ? '1 : ((64'd1 << m) - 64'd1);
      if (md == 2'b00) return (x ^ y) & mask;
      if (md == 2'b11) return (x + y) & mask;
      aa = x & mask;
      bb = ((md == 2'b10) ? x : y) & mask;
      p  = '0;
      for (int i = 0; i < m; i++) begin
         if (bb[0]) p = p ^ aa;
         bb = bb >> 1;
         if (aa[m-1]) aa = ((aa << 1) ^ poly) & mask;
         else         aa = (aa << 1) & mask;
      end
      return p;
   endfunction

   task automatic drive_garbage();
      t_in_valid = 1'($urandom_range(1));
      t_a        = 1'($urandom_range(1));
      t_b        = 1'($urandom_range(1));
      t_mode     = 2'($urandom_range(3));
   endtask

   task automatic send_bits(input logic [63:0] x, input logic [63:0] y, input logic [1:0] md,
                            input int nbits, input int gap_pct);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         while ($urandom_range(99) < gap_pct) begin
            t_in_valid = 1'b0;
            t_a        = 1'($urandom_range(1));
            t_b        = 1'($urandom_range(1));
            t_mode     = 2'($urandom_range(3));
            @(negedge clk);
         end
         t_in_valid = 1'b1;
         t_a        = x[i];
         t_b        = y[i];
         t_mode     = md;
      end
   endtask

   task automatic collect(input int exp_lat, input int stall_pct, output logic [63:0] res);
      int          k, idx;
      logic [63:0] lmask;
      logic        stalled, held_sum, held_last;
      res = '0; k = 0; idx = 0; lmask = '0; stalled = 1'b0;
      held_sum = 1'b0; held_last = 1'b0;
      do begin
         @(negedge clk);
         k++;
         drive_garbage();
         t_out_ready = 1'($urandom_range(1));
      end while (!o_out_valid && k < 300);
      if (!o_out_valid) begin
         check_eq("valid_timeout", 64'(o_out_valid), 64'd1);
         return;
      end
      check_eq("latency", 64'(k), 64'(exp_lat));
      while (idx < cur_m && k < 3000) begin
         if (!o_out_valid) begin
            check_eq("valid_drop", 64'(o_out_valid), 64'd1);
            return;
         end
         if (stalled) begin
            check_eq("stall_sum", 64'(o_sum), 64'(held_sum));
            check_eq("stall_last", 64'(o_out_last), 64'(held_last));
         end
         if ($urandom_range(99) < stall_pct) begin
            t_out_ready = 1'b0;
            stalled     = 1'b1;
            held_sum    = o_sum;
            held_last   = o_out_last;
         end else begin
            t_out_ready = 1'b1;
            stalled     = 1'b0;
            res[idx]    = o_sum;
            if (o_out_last) lmask[idx] = 1'b1;
            idx++;
         end
         if (idx < cur_m) begin
            @(negedge clk);
            k++;
            drive_garbage();
         end
      end
      if (idx < cur_m) begin
         check_eq("out_timeout", 64'(idx), 64'(cur_m));
         return;
      end
      @(posedge clk);
      #1;
      t_in_valid  = 1'b0;
      t_out_ready = 1'b0;
      check_eq("b2b_ready", 64'(o_in_ready), 64'd1);
      check_eq("idle_valid", 64'(o_out_valid), 64'd0);
      check_eq("last_pos", lmask, 64'd1 << (cur_m - 1));
   endtask

   task automatic run_frame(input string tag, input logic [63:0] x, input logic [63:0] y,
                            input logic [1:0] md, input logic [63:0] exp,
                            input int gap_pct, input int stall_pct);
      logic [63:0] got;
      int          lat;
      lat = (md == 2'b00 || md == 2'b11) ? 2 : cur_m + 1;
      send_bits(x, y, md, cur_m, gap_pct);
      collect(lat, stall_pct, got);
      check_eq(tag, got, exp);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      t_in_valid  = 1'b0;
      t_out_ready = 1'b0;
      resetn      = 1'b0;
      #1;
      check_eq({tag, "_valid"}, 64'(o_out_valid), 64'd0);
      check_eq({tag, "_sum"}, 64'(o_sum), 64'd0);
      check_eq({tag, "_last"}, 64'(o_out_last), 64'd0);
      check_eq({tag, "_ready"}, 64'(o_in_ready), 64'd1);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_eq({tag, "_ready_post"}, 64'(o_in_ready), 64'd1);
      check_eq({tag, "_valid_post"}, 64'(o_out_valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] x, y, mask;
      logic [1:0]  md;
      int          k;
      n_total = 0; n_bad = 0;
      sel = 1'b0; resetn = 1'b0;
      t_in_valid = 1'b0; t_a = 1'b0; t_b = 1'b0; t_mode = 2'b00; t_out_ready = 1'b0;
      cur_m = 8; cur_poly = 64'h1B;

      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check_eq("rst_ready", 64'(o_in_ready), 64'd1);
         check_eq("rst_valid", 64'(o_out_valid), 64'd0);
         check_eq("rst_sum", 64'(o_sum), 64'd0);
         check_eq("rst_last", 64'(o_out_last), 64'd0);
      end
      sel = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      // Directed known answers, AES field
      run_frame("mul_57_83", 64'h57, 64'h83, 2'b01, 64'hC1, 0, 0);
      run_frame("mul_53_ca", 64'h53, 64'hCA, 2'b01, 64'h01, 0, 0);
      run_frame("xor_57_83", 64'h57, 64'h83, 2'b00, 64'hD4, 0, 0);
      run_frame("iadd_ff_01", 64'hFF, 64'h01, 2'b11, 64'h00, 0, 0);
      run_frame("sqr_80", 64'h80, 64'($urandom_range(255)), 2'b10, 64'h9A, 0, 0);
      run_frame("sqr_02", 64'h02, 64'($urandom_range(255)), 2'b10, 64'h04, 0, 0);

      // Random frames with input gaps and output stalls
      for (int i = 0; i < 24; i++) begin
         x  = 64'($urandom_range(255));
         y  = 64'($urandom_range(255));
         md = 2'($urandom_range(3));
         run_frame("rand8", x, y, md, ref_op(x, y, md, 8, 64'h1B), 30, 30);
      end

      // Reset after 5 input bits
      send_bits(64'hFF, 64'hFF, 2'b01, 5, 0);
      do_reset("rst_load");
      run_frame("after_rst_load", 64'h57, 64'h83, 2'b01, 64'hC1, 20, 20);

      // Reset mid-compute
      send_bits(64'h57, 64'h83, 2'b01, 8, 0);
      repeat (3) begin
         @(negedge clk);
         t_in_valid = 1'b0;
      end
      do_reset("rst_comp");
      run_frame("after_rst_comp", 64'h57, 64'h83, 2'b01, 64'hC1, 20, 20);

      // Reset mid-output after a few bits were taken
      send_bits(64'h57, 64'h83, 2'b01, 8, 0);
      k = 0;
      do begin
         @(negedge clk);
         t_in_valid = 1'b0;
         t_out_ready = 1'b0;
         k++;
      end while (!o_out_valid && k < 50);
      check_eq("rst_out_reach", 64'(o_out_valid), 64'd1);
      t_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      do_reset("rst_out");
      run_frame("after_rst_out", 64'h57, 64'h83, 2'b01, 64'hC1, 20, 20);

      // Default-parameter instance: m=32, POLY=0x8D
      @(negedge clk);
      sel = 1'b1; cur_m = 32; cur_poly = 64'h8D;
      mask = 64'hFFFF_FFFF;
      run_frame("mul32_x_x31", 64'h2, 64'h8000_0000, 2'b01, 64'h8D, 0, 0);
      run_frame("iadd32_ff", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 2'b11, 64'hFFFF_FFFE, 0, 0);
      for (int i = 0; i < 8; i++) begin
         x  = 64'($urandom) & mask;
         y  = 64'($urandom) & mask;
         md = 2'($urandom_range(3));
         run_frame("rand32", x, y, md, ref_op(x, y, md, 32, 64'h8D), 20, 20);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/gf_serial_alu.md
# gf_serial_alu

Bit-serial GF(2^m) arithmetic unit with a mode select and valid/ready framing on both serial sides. Two operands arrive LSB-first on single-bit inputs and are deserialised. The selected operation runs: GF add, GF multiply modulo an irreducible polynomial, GF square, or integer add. The result is serialised LSB-first. It is the parametrised successor of the fixed-function serial adder top and sits between serial link logic and the GF test harness.

## Interface
- DATA_WIDTH, 32: field degree m; operand/result width in bits (≥2).
- POLY, 32'h0000_008D: irreducible polynomial low terms. x^m is implicit. Bit i is the coefficient of x^i.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  a/b bits valid this cycle.
- in_ready  out  1  unit accepts input bits (high only in LOAD).
- a  in  1  operand A serial bit, LSB first.
- b  in  1  operand B serial bit, LSB first.
- mode  in  2  00 GF add (XOR), 01 GF mul, 10 GF square (A·A, B ignored), 11 integer add mod 2^m; sampled with the last input bit.
- out_valid  out  1  sum bit valid.
- out_ready  in  1  downstream accepts sum bit.
- sum  out  1  result serial bit, LSB first.
- out_last  out  1  high with bit m-1 of the result.

## Operation
- FSM states: LOAD, COMPUTE, OUT.
- LOAD
  - in_ready=1.
  - Each cycle with in_valid=1, a and b shift into op_a/op_b (shift right, new bit into MSB) and bit_cnt increments.
  - in_valid=0 holds everything; gaps are allowed.
  - On accepting the bit with bit_cnt==m-1: latch mode, clear bit_cnt, go to COMPUTE.
- COMPUTE
  - Modes 00 and 11: one cycle.
    - 00: res=op_a^op_b.
    - 11: res=(op_a+op_b) mod 2^m; carry-out is discarded.
  - Modes 01 and 10: m cycles, Horner, MSB of multiplier first.
    - Each step: acc = xtime(acc) ^ (mbit ? op_a : 0).
    - xtime(x) = (x<<1)[m-1:0] ^ (x[m-1] ? POLY : 0).
    - Multiplier is op_b for mode 01 and op_a for mode 10.
    - acc is cleared on entry; after the m-th step res=acc.
  - Then go to OUT with bit_cnt cleared.
- OUT
  - out_valid=1, sum=res[0], out_last=(bit_cnt==m-1).
  - On out_valid&out_ready: shift res right, increment bit_cnt.
  - After the last bit is accepted, go to LOAD with bit_cnt cleared.
  - out_ready=0 stalls indefinitely; sum and out_last stay stable.
- Any input bits presented while in_ready=0 are ignored.
- Reset (any state, including mid-frame or mid-compute)
  - State goes to LOAD; op_a, op_b, res, acc, bit_cnt and the latched mode are zeroed.
  - The partial frame is discarded.
- Outputs during and immediately after reset: in_ready=1 (LOAD), out_valid=0, sum=0, out_last=0.

## Timing
- The last input bit is accepted at edge T.
- Add modes: out_valid first high in cycle T+2; first sum bit visible that cycle.
- Mul and square modes: out_valid first high in cycle T+1+m.
- Output phase takes m cycles with out_ready held high.
- Back-to-back frames: in_ready rises the cycle after out_last is accepted.
- No input/output overlap: a single frame is in flight.
- All outputs are registered or decoded from registered state only; there is no combinational path from a, b or in_valid to any output.
- out_ready drives only the shift/advance enable.

## Structure
- Package gf_pkg holds:
  - mode encodings (GF_ADD, GF_MUL, GF_SQR, INT_ADD);
  - FSM state enum;
  - default POLY constant;
  - an xtime function parametrised by width and polynomial.
- Sub-module gf_serial_mul: start/done iterative Horner multiplier (op_a, multiplier, POLY → product, m cycles).
  - The top FSM sequences the load/output shift registers and the mode mux around it.

## Test plan
Bench runs DATA_WIDTH=8, POLY=8'h1B (AES field) unless noted.
- GF mul: A=0x57, B=0x83, mode 01, out_ready=1 → out_valid at T+9; serial bits give 0xC1; out_last on 8th bit. A=0x53, B=0xCA → 0x01.
- GF add/int add: A=0x57, B=0x83, mode 00 → 0xD4 at T+2. A=0xFF, B=0x01, mode 11 → 0x00 (carry dropped).
- GF square: A=0x80, B=random, mode 10 → 0x9A. A=0x02 → 0x04.
- Handshake stress:
  - random in_valid gaps and random out_ready deassertion → results unchanged;
  - sum/out_last stable while stalled;
  - bits offered while in_ready=0 have no effect.
- Reset: assert resetn=0 after 5 input bits, and separately mid-COMPUTE and mid-OUT.
  - out_valid drops immediately and in_ready=1 after release.
  - A full fresh frame 0x57·0x83 then returns 0xC1.
- Default parameters (m=32, POLY=0x8D): GF mul A=0x00000002, B=0x80000000 → 0x0000008D. Mode 11 with A=B=0xFFFFFFFF → 0xFFFFFFFE.
